// File: rtl/sd_cmd_engine.sv
// SD CMD-line command engine: send a frame, collect and check the response, retry, wait out R1b busy.
// Accepts one command at a time (cmd_ready only in IDLE); completion is flagged by a one-cycle done pulse.
module sd_cmd_engine #(
  parameter int          RESP_TIMEOUT    = 64,
  parameter int          BUSY_TIMEOUT    = 65535,
  parameter int          MAX_RETRIES     = 2,
  parameter logic [31:0] STATUS_ERR_MASK = 32'hFDF9_8008
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [2:0]   resp_type,
  output logic         tx_start,
  output logic [37:0]  tx_frame,
  input  logic         tx_done,
  output logic         rx_en,
  input  logic         rx_done,
  input  logic         rx_crc_err,
  input  logic [126:0] rx_resp,
  input  logic         dat0,
  output logic         done,
  output logic [4:0]   err,
  output logic [126:0] resp_out,
  output logic [1:0]   retry_cnt
);

  localparam int TMAX = (RESP_TIMEOUT > BUSY_TIMEOUT) ? RESP_TIMEOUT : BUSY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RESP_LAST = TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TIMEOUT - 1);

  localparam logic [2:0] RT_NONE = 3'd0;
  localparam logic [2:0] RT_R1   = 3'd1;
  localparam logic [2:0] RT_R1B  = 3'd2;
  localparam logic [2:0] RT_R3   = 3'd4;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RESP, CHECK, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic [2:0]     rtype, rtype_nxt;
  logic           crc_q, crc_nxt;
  logic [TW-1:0]  timer, timer_nxt, timer_inc;
  logic [37:0]    frame_nxt;
  logic [126:0]   resp_nxt;
  logic [4:0]     err_nxt, fail_bit;
  logic [1:0]     retry_nxt;
  logic           retry_req, can_retry, is_r1;

  // Saturating so a long busy wait can never alias back to zero
  assign timer_inc = (&timer) ? timer : timer + TW'(1);
  assign can_retry = int'(retry_cnt) < MAX_RETRIES;
  assign is_r1     = (rtype == RT_R1) || (rtype == RT_R1B);

  always_comb begin
    state_nxt = state;
    rtype_nxt = rtype;
    crc_nxt   = crc_q;
    timer_nxt = timer;
    frame_nxt = tx_frame;
    resp_nxt  = resp_out;
    err_nxt   = err;
    retry_nxt = retry_cnt;
    retry_req = 1'b0;
    fail_bit  = '0;
    cmd_ready = 1'b0;
    tx_start  = 1'b0;
    rx_en     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          frame_nxt = {cmd_index, cmd_arg};
          rtype_nxt = (resp_type > RT_R3) ? RT_NONE : resp_type;
          err_nxt   = '0;
          retry_nxt = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) begin
          timer_nxt = '0;
          state_nxt = (rtype == RT_NONE) ? DONE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        rx_en     = 1'b1;
        timer_nxt = timer_inc;
        if (rx_done) begin
          resp_nxt  = rx_resp;
          crc_nxt   = rx_crc_err;
          state_nxt = CHECK;
        end else if (timer == RESP_LAST) begin
          retry_req = 1'b1;
          fail_bit  = 5'b00001;
        end
      end
      CHECK: begin
        if (crc_q && (rtype != RT_R3)) begin
          retry_req = 1'b1;
          fail_bit  = 5'b00010;
        end else if (is_r1 && (resp_out[125:120] != tx_frame[37:32])) begin
          retry_req = 1'b1;
          fail_bit  = 5'b00100;
        end else if (is_r1 && |(resp_out[119:88] & STATUS_ERR_MASK)) begin
          err_nxt[3] = 1'b1;
          state_nxt  = DONE;
        end else if (rtype == RT_R1B) begin
          timer_nxt = '0;
          state_nxt = BUSY;
        end else begin
          state_nxt = DONE;
        end
      end
      BUSY: begin
        timer_nxt = timer_inc;
        if (dat0) begin
          state_nxt = DONE;
        end else if (timer == BUSY_LAST) begin
          err_nxt[4] = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Timeout, CRC and index failures share one re-send path
    if (retry_req) begin
      if (can_retry) begin
        retry_nxt = retry_cnt + 2'd1;
        state_nxt = SEND;
      end else begin
        err_nxt   = err | fail_bit;
        state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rtype     <= RT_NONE;
      crc_q     <= 1'b0;
      timer     <= '0;
      tx_frame  <= '0;
      resp_out  <= '0;
      err       <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rtype     <= rtype_nxt;
      crc_q     <= crc_nxt;
      timer     <= timer_nxt;
      tx_frame  <= frame_nxt;
      resp_out  <= resp_nxt;
      err       <= err_nxt;
      retry_cnt <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: success, CRC/timeout retries, index/status errors, R1b busy, reset abort.
module tb_sd_cmd_engine;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [2:0]   resp_type;
  logic         tx_start;
  logic [37:0]  tx_frame;
  logic         tx_done;
  logic         rx_en;
  logic         rx_done;
  logic         rx_crc_err;
  logic [126:0] rx_resp;
  logic         dat0;
  logic         done;
  logic [4:0]   err;
  logic [126:0] resp_out;
  logic [1:0]   retry_cnt;

  int errors = 0;
  int checks = 0;
  int tx_cnt = 0;
  int done_cnt = 0;
  int tx_base, done_base, n;
  logic [126:0] r;

  sd_cmd_engine #(
    .RESP_TIMEOUT(64), .BUSY_TIMEOUT(65535), .MAX_RETRIES(2), .STATUS_ERR_MASK(32'hFDF9_8008)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_type(resp_type),
    .tx_start(tx_start), .tx_frame(tx_frame), .tx_done(tx_done),
    .rx_en(rx_en), .rx_done(rx_done), .rx_crc_err(rx_crc_err), .rx_resp(rx_resp),
    .dat0(dat0), .done(done), .err(err), .resp_out(resp_out), .retry_cnt(retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) tx_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [126:0] mk_r1(input logic [5:0] idx, input logic [31:0] st);
    logic [126:0] v;
    v = '0;
    v[125:120] = idx;
    v[119:88]  = st;
    v[7:0]     = 8'h5B;
    return v;
  endfunction

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] rt);
    tx_base   = tx_cnt;
    done_base = done_cnt;
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    resp_type = rt;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for tx_start, then play the serializer: tx_done one cycle later
  task automatic serve_tx();
    int k;
    k = 0;
    while (!tx_start && k < 10) begin
      tick();
      k++;
    end
    check("tx_start_seen", tx_start, 1'b1);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic respond(input logic [126:0] v, input logic crc);
    rx_done    = 1'b1;
    rx_resp    = v;
    rx_crc_err = crc;
    tick();
    rx_done    = 1'b0;
    rx_crc_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0; resp_type = '0;
    tx_done = 1'b0; rx_done = 1'b0; rx_crc_err = 1'b0; rx_resp = '0; dat0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_outputs", {tx_start, rx_en, done, err, retry_cnt}, '0);
    check("rst_frame", tx_frame, '0);
    check("rst_resp", resp_out, '0);
    reset = 1'b0;
    tick();

    // R1 CMD13 success
    issue(6'd13, 32'h1234_0000, 3'd1);
    check("t1_tx_start", tx_start, 1'b1);
    check("t1_frame", tx_frame, {6'd13, 32'h1234_0000});
    check("t1_ready_busy", cmd_ready, 1'b0);
    serve_tx();
    check("t1_rx_en", rx_en, 1'b1);
    tick(); tick();
    respond(mk_r1(6'd13, 32'h0), 1'b0);
    check("t1_resp_out", resp_out, mk_r1(6'd13, 32'h0));
    tick();
    check("t1_done", done, 1'b1);
    check("t1_err", err, 5'b00000);
    tick();
    check("t1_idle", {cmd_ready, done}, 2'b10);
    check("t1_tx_pulses", tx_cnt - tx_base, 1);
    check("t1_done_pulses", done_cnt - done_base, 1);

    // CRC error on every attempt
    issue(6'd17, 32'hDEAD_BEEF, 3'd1);
    for (int a = 0; a < 3; a++) begin
      serve_tx();
      tick();
      respond(mk_r1(6'd17, 32'h0), 1'b1);
    end
    tick();
    check("t2_done", done, 1'b1);
    check("t2_err", err, 5'b00010);
    check("t2_retry", retry_cnt, 2'd2);
    check("t2_tx_pulses", tx_cnt - tx_base, 3);
    tick();

    // R2 response timeout on every attempt
    issue(6'd2, 32'h0, 3'd3);
    for (int a = 0; a < 3; a++) begin
      serve_tx();
      n = 0;
      while (rx_en && n < 200) begin
        tick();
        n++;
      end
      check("t3_timeout_len", n, 64);
    end
    check("t3_done", done, 1'b1);
    check("t3_err", err, 5'b00001);
    check("t3_retry", retry_cnt, 2'd2);
    check("t3_tx_pulses", tx_cnt - tx_base, 3);
    tick();

    // R2 with rx_done on the terminal timeout cycle
    issue(6'd2, 32'h0, 3'd3);
    serve_tx();
    repeat (63) tick();
    check("t4_rx_en_last", rx_en, 1'b1);
    r = 127'h3F_FFFF_FFFF_0123_4567_89AB_CDEF_0011;
    respond(r, 1'b0);
    tick();
    check("t4_done", done, 1'b1);
    check("t4_err", err, 5'b00000);
    check("t4_retry", retry_cnt, 2'd0);
    check("t4_resp", resp_out, r);
    tick();

    // Index mismatch once, then success; a second cmd_valid mid-flight is ignored
    issue(6'd13, 32'h0000_0042, 3'd1);
    serve_tx();
    cmd_valid = 1'b1; cmd_index = 6'd40; cmd_arg = 32'hFFFF_FFFF;
    tick();
    cmd_valid = 1'b0;
    check("t5_frame_hold", tx_frame, {6'd13, 32'h0000_0042});
    respond(mk_r1(6'd12, 32'h0), 1'b0);
    serve_tx();
    check("t5_retry_mid", retry_cnt, 2'd1);
    respond(mk_r1(6'd13, 32'h0), 1'b0);
    tick();
    check("t5_done", done, 1'b1);
    check("t5_err", err, 5'b00000);
    check("t5_tx_pulses", tx_cnt - tx_base, 2);
    tick();

    // R1b CMD7, busy for 100 cycles
    dat0 = 1'b0;
    issue(6'd7, 32'hABCD_0000, 3'd2);
    serve_tx();
    respond(mk_r1(6'd7, 32'h0), 1'b0);
    tick();
    repeat (100) tick();
    check("t6_still_busy", done, 1'b0);
    dat0 = 1'b1;
    tick();
    check("t6_done", done, 1'b1);
    check("t6_err", err, 5'b00000);
    tick();

    // R1b with DAT0 stuck low
    dat0 = 1'b0;
    issue(6'd7, 32'hABCD_0000, 3'd2);
    serve_tx();
    respond(mk_r1(6'd7, 32'h0), 1'b0);
    tick();
    n = 0;
    while (!done && n < 70000) begin
      tick();
      n++;
    end
    check("t7_busy_len", n, 65535);
    check("t7_err", err, 5'b10000);
    dat0 = 1'b1;
    tick();

    // Card status error: no retry
    issue(6'd13, 32'h1234_0000, 3'd1);
    serve_tx();
    respond(mk_r1(6'd13, 32'h8000_0000), 1'b0);
    tick();
    check("t8_done", done, 1'b1);
    check("t8_err", err, 5'b01000);
    check("t8_retry", retry_cnt, 2'd0);
    check("t8_tx_pulses", tx_cnt - tx_base, 1);
    tick();

    // Reset during WAIT_RESP
    issue(6'd13, 32'h5555_0000, 3'd1);
    serve_tx();
    tick(); tick();
    reset = 1'b1;
    #1;
    check("t9_async_ready", cmd_ready, 1'b1);
    check("t9_async_outs", {tx_start, rx_en, done, err, retry_cnt}, '0);
    check("t9_async_frame", tx_frame, '0);
    check("t9_async_resp", resp_out, '0);
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    check("t9_no_done", done_cnt - done_base, 0);
    check("t9_idle", cmd_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_engine.md
SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 64: clk cycles allowed from end of TX to rx_done.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 65535: clk cycles allowed for DAT0 busy release (R1b).
REQ-003 SHALL have parameter MAX_RETRIES, default 2: re-sends permitted after a retryable failure.
REQ-004 SHALL have parameter STATUS_ERR_MASK, default 32'hFDF9_8008: R1 card-status error bits.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  engine can accept a command.
REQ-009 cmd_index  in  6  command index.
REQ-010 cmd_arg  in  32  command argument.
REQ-011 resp_type  in  3  0=none, 1=R1, 2=R1b, 3=R2, 4=R3; 5-7 treated as none.
REQ-012 tx_start  out  1  one-cycle pulse to the CMD-line serializer.
REQ-013 tx_frame  out  38  {index, arg}, stable from accept to done.
REQ-014 tx_done  in  1  serializer finished the frame.
REQ-015 rx_en  out  1  response receiver armed.
REQ-016 rx_done  in  1  response fully received.
REQ-017 rx_crc_err  in  1  CRC7 mismatch, valid with rx_done.
REQ-018 rx_resp  in  127  response bits, valid with rx_done.
REQ-019 dat0  in  1  DAT0 line level (0 = card busy).
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 err  out  5  [0] resp timeout, [1] CRC, [2] index mismatch, [3] card status, [4] busy timeout.
REQ-022 resp_out  out  127  last captured response.
REQ-023 retry_cnt  out  2  retries used by the current or last command.

Function
REQ-024 States SHALL be IDLE, SEND, WAIT_TX, WAIT_RESP, CHECK, BUSY, DONE.
REQ-025 IDLE: cmd_ready=1; on cmd_valid, latch index/arg/resp_type, clear err and retry_cnt, go to SEND next cycle.
REQ-026 cmd_ready SHALL be 0 outside IDLE; cmd_valid outside IDLE is ignored.
REQ-027 SEND: tx_start=1 for exactly one cycle, then WAIT_TX.
REQ-028 WAIT_TX: on tx_done, go to DONE if resp_type is none, otherwise to WAIT_RESP with the timer cleared.
REQ-029 WAIT_RESP: rx_en=1 and timer increments each cycle. On rx_done, capture rx_resp into resp_out and go to CHECK. At timer==RESP_TIMEOUT-1 without rx_done, record a timeout failure.
REQ-030 If rx_done and the timeout terminal count coincide, rx_done SHALL win.
REQ-031 CHECK (one cycle), failure checks in this order:
 - CRC: rx_crc_err, ignored for R3.
 - Index mismatch: resp_out[125:120]!=cmd_index, R1/R1b only.
 - Card status: (resp_out[119:88] & STATUS_ERR_MASK)!=0, R1/R1b only.
REQ-032 Timeout, CRC and index failures SHALL be retryable: if retry_cnt<MAX_RETRIES, increment retry_cnt and go to SEND; otherwise set the err bit and go to DONE.
REQ-033 A card-status failure SHALL set err[3] and go to DONE with no retry.
REQ-034 On CHECK success, R1b SHALL go to BUSY; all other types go to DONE.
REQ-035 BUSY: timer cleared on entry; exit to DONE on the first cycle dat0==1. At timer==BUSY_TIMEOUT-1 with dat0==0, set err[4] and go to DONE.
REQ-036 DONE: done=1 for one cycle, then IDLE. err, resp_out and retry_cnt SHALL hold until the next accept.
REQ-037 The timer SHALL be wide enough for max(RESP_TIMEOUT, BUSY_TIMEOUT) and SHALL never wrap.

Reset
REQ-038 Reset, including mid-operation, SHALL force IDLE asynchronously with all outputs zero except cmd_ready=1. Any in-flight command is dropped without a done pulse.

Verification
REQ-039 R1 CMD13, arg 32'h1234_0000: tx_done, then rx_done with index 13, status 0 -> done, err=0, tx_start pulsed once.
REQ-040 R1 with rx_crc_err on every attempt -> 3 tx_start pulses, then done with err=5'b00010, retry_cnt=2.
REQ-041 R2 with no rx_done -> timeout after 64 cycles per attempt; final err=5'b00001. A second run with rx_done on the terminal cycle -> success.
REQ-042 R1b CMD7 with dat0 low for 100 cycles -> done on the cycle after dat0 rises, err=0. With dat0 held low -> err[4] after 65535 cycles.
REQ-043 R1 response with status bit 31 set -> err=5'b01000, no retry. Assert reset during WAIT_RESP -> IDLE immediately, no done pulse.
